multicycle_ctrl_fsm: RTL
========================

Name: multicycle_ctrl_fsm

Overview:
- Multicycle sequencer for the ARM-subset processor. It replaces single-cycle decode with a Fetch/Decode/Execute/Memory/Writeback state machine.
- Drives the shared-memory datapath: one memory for instructions and data, one ALU reused for PC+4.
- Owns the NZCV flags register and the condition check, so suppressed instructions never write state.
- Stalls on a memory ready handshake.

Parameters:
- MEM_HANDSHAKE, 1, 1 = wait in memory states until mem_ready; 0 = mem_ready treated as constant 1.
- RST_PC_WRITE, 0, value of pc_write during reset (kept 0; reserved).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cond  in  4  instr[31:28].
- op  in  2  instr[27:26]: 00 DP, 01 MEM, 10 BR.
- funct  in  6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (MEM: [0]=L).
- rd  in  4  instr[15:12].
- alu_flags  in  4  {N,Z,C,V} from ALU, same cycle.
- mem_ready  in  1  memory access completes this cycle.
- ir_write  out  1  latch instruction.
- pc_write  out  1  update PC.
- adr_src  out  1  0 = PC, 1 = ALU result register.
- mem_write  out  1  store strobe.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = rA, 1 = PC.
- alu_src_b  out  2  00 = rB, 01 = ext imm, 10 = const 4.
- result_src  out  2  00 = ALUOut reg, 01 = read data, 10 = ALU direct.
- imm_src  out  2  = op.
- reg_src  out  2  [0] = (op==10), [1] = (op==01).
- alu_ctrl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 PASSB.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset (rst==0, asynchronous):
  - state = FETCH; flags = 0000.
  - All strobes 0: ir_write, pc_write, mem_write, reg_write.
  - All selects 0.
- States (4-bit encoding):
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.
  - Codes 10-15 recover to FETCH next cycle.
- FETCH:
  - adr_src=0; alu_src_a=1, alu_src_b=10, alu_ctrl=ADD, result_src=10.
  - When mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise hold with all strobes 0.
- DECODE:
  - Computes PC+8: alu_src_a=1, alu_src_b=10, result_src=10.
  - Next state:
    - cond fails → FETCH.
    - op==01 → MEMADR.
    - op==10 → BRANCH.
    - op==00 with I=1 → EXECI; I=0 → EXECR.
    - op==11 → FETCH (undefined; no writes).
- MEMADR: alu_src_b=01, alu_ctrl=ADD. Next: L=1 → MEMRD, L=0 → MEMWR.
- MEMRD: adr_src=1; wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWR: adr_src=1, mem_write=1. mem_write stays high until the mem_ready cycle (inclusive), then FETCH.
- EXECR / EXECI:
  - alu_src_b = 00 / 01; alu_ctrl decoded from cmd.
  - cmd map: 0100 ADD, 0010 SUB, 1010 CMP→SUB, 0000 AND, 1100 ORR, 1101 MOV→PASSB. Any other cmd → ADD with no writeback.
  - Then ALUWB.
- ALUWB:
  - result_src=00.
  - reg_write=1 unless cmd==CMP or cmd unsupported.
  - If rd==1111 with reg_write: pc_write=1 instead of reg_write, i.e. a branch via PC write.
  - Then FETCH.
- BRANCH: alu_src_b=01, alu_ctrl=ADD, result_src=10, pc_write=1, then FETCH.
- Flags:
  - Captured at the end of EXECR/EXECI when (S==1 or cmd==CMP), and only on that cycle.
  - N,Z always captured; C,V only for ADD/SUB/CMP.
- Condition check uses the registered flags.
  - EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V.
  - HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 → 0.
- Latency (mem_ready=1):
  - DP 4 cycles, LDR 5, STR 4, B 3.
  - Each mem_ready=0 cycle adds 1.
- Outputs are combinational from state and registered inputs; no glitch constraints beyond that.
- Reset mid-operation aborts the instruction immediately; no write strobe may be asserted while rst==0.

Decomposition:
- Package cpu_ctrl_pkg:
  - state enum.
  - op constants.
  - cmd constants.
  - alu_ctrl constants.
  - src-select constants.
- Sub-module cond_check: cond, flags → cond_ok (combinational).

Test Plan:
- Reset: rst=0 for 2 cycles, then 1 → state_o=0, all strobes 0; FETCH with mem_ready=1 → ir_write=1, pc_write=1, next state 1.
- ADD r5: cond=1110, op=00, funct=001000, rd=0101 → states 0,1,7,8; reg_write=1 only in state 8; alu_ctrl=0000 in state 7; flags unchanged.
- SUBS then EQ: funct=000101 with alu_flags=0100 → flags=0100. Next instr cond=0000 executes. cond=0001 → DECODE→FETCH, no reg_write/pc_write.
- LDR stall: op=01, funct=011001, mem_ready held 0 for 3 cycles in MEMRD → 8 cycles total; reg_write once, result_src=01.
- STR: op=01, funct=011000, mem_ready=0 for 1 cycle → mem_write high exactly 2 cycles; adr_src=1; no reg_write.
- Branch and rd=PC: op=10, cond=1110 → BRANCH pc_write=1, 3 cycles. DP with rd=1111 → pc_write=1 in ALUWB, reg_write=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset control path.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_ORR   = 4'b0011;
  localparam logic [3:0] ALU_PASSB = 4'b0100;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic [3:0] cmd_alu(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: return ALU_SUB;
      CMD_AND:          return ALU_AND;
      CMD_ORR:          return ALU_ORR;
      CMD_MOV:          return ALU_PASSB;
      default:          return ALU_ADD;
    endcase
  endfunction

  // Unsupported commands still run through the ALU but must not write back.
  function automatic logic cmd_writes(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_AND) ||
           (cmd == CMD_ORR) || (cmd == CMD_MOV);
  endfunction

  function automatic logic cmd_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the registered NZCV flags.
module cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ok
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'h0: cond_ok = z;
      4'h1: cond_ok = ~z;
      4'h2: cond_ok = c;
      4'h3: cond_ok = ~c;
      4'h4: cond_ok = n;
      4'h5: cond_ok = ~n;
      4'h6: cond_ok = v;
      4'h7: cond_ok = ~v;
      4'h8: cond_ok = c & ~z;
      4'h9: cond_ok = ~c | z;
      4'ha: cond_ok = (n == v);
      4'hb: cond_ok = (n != v);
      4'hc: cond_ok = ~z & (n == v);
      4'hd: cond_ok = z | (n != v);
      4'he: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Fetch/decode/execute/memory/writeback sequencer with NZCV flags; memory states
// stall on mem_ready. All strobes are forced low while rst is asserted.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit RST_PC_WRITE  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] alu_ctrl,
  output logic [3:0] state_o
);

  state_t     state, state_nxt;
  logic [3:0] flags;
  logic       cond_ok, ready, flags_we;
  logic [3:0] cmd;
  logic       i_bit, s_bit;

  assign cmd     = funct[4:1];
  assign i_bit   = funct[5];
  assign s_bit   = funct[0];
  assign ready   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state_o = state;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags),
    .cond_ok (cond_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  // C and V only carry meaning for arithmetic ops; logical ops leave them alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags <= 4'b0000;
    end else if (flags_we) begin
      flags[3:2] <= alu_flags[3:2];
      if (cmd_arith(cmd)) flags[1:0] <= alu_flags[1:0];
    end
  end

  always_comb begin
    state_nxt  = state;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    result_src = RES_ALUOUT;
    alu_ctrl   = ALU_ADD;
    flags_we   = 1'b0;
    imm_src    = op;
    reg_src    = {op == OP_MEM, op == OP_BR};

    case (state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (!cond_ok) begin
          state_nxt = S_FETCH;
        end else begin
          case (op)
            OP_MEM:  state_nxt = S_MEMADR;
            OP_BR:   state_nxt = S_BRANCH;
            OP_DP:   state_nxt = i_bit ? S_EXECI : S_EXECR;
            default: state_nxt = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        state_nxt = s_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        if (ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
      end
      S_MEMWR: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (ready) state_nxt = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_b = (state == S_EXECI) ? SRCB_IMM : SRCB_REG;
        alu_ctrl  = cmd_alu(cmd);
        flags_we  = s_bit | (cmd == CMD_CMP);
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        if (cmd_writes(cmd)) begin
          if (rd == 4'hf) pc_write  = 1'b1;
          else            reg_write = 1'b1;
        end
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALU;
        pc_write   = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase

    if (!rst) begin
      ir_write   = 1'b0;
      pc_write   = RST_PC_WRITE;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      result_src = 2'b00;
      alu_ctrl   = 4'b0000;
      imm_src    = 2'b00;
      reg_src    = 2'b00;
      flags_we   = 1'b0;
    end
  end

endmodule
